gmii_link_mon: RTL and testbench

GMII_LINK_MON -- requirements
Module: gmii_link_mon

---
 rtl/gmii_link_mon.sv | 195 +++++++++++++++++++
 tb/tb_gmii_link_mon.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_link_mon.sv
// -----------------------------------------------------------------------------
// gmii_link_mon
//
// Per-channel monitor of a PHY "gigabit" indicator. Each channel synchronises
// its indicator into clk_125M and qualifies it before selecting the 125 MHz TX
// clock source (ge_mode). A loss of the indicator is tolerated for a hold-off
// period before GE mode is dropped. Every ge_mode transition sets a sticky
// status bit that can raise an interrupt. A saturating counter per channel
// records how many times the link came up.
//
// The block only produces the select. The clock mux itself (BUFGMUX) lives
// outside this module.
//
// Ports
//   clk_125M   in   1            single clock, rising edge
//   rst        in   1            synchronous active-high reset
//   ge_ind     in   N_CH         PHY gigabit indicators (asynchronous)
//   irq_mask   in   N_CH         1 = channel does not contribute to irq
//   sts_clr    in   N_CH         write-1-to-clear strobe for ge_change
//   ge_mode    out  N_CH         1 = select the 125 MHz TX clock
//   ge_change  out  N_CH         sticky: ge_mode changed
//   irq        out  1            registered OR of unmasked ge_change
//   link_cnt   out  N_CH*CNT_W   saturating link-up counts, ch i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module gmii_link_mon #(
    parameter int N_CH        = 1,
    parameter int TIMER_W     = 28,
    parameter int HOLD_CYCLES = 16777215,
    parameter int QUAL_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic                    clk_125M,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ge_ind,
    input  logic [N_CH-1:0]         irq_mask,
    input  logic [N_CH-1:0]         sts_clr,
    output logic [N_CH-1:0]         ge_mode,
    output logic [N_CH-1:0]         ge_change,
    output logic                    irq,
    output logic [N_CH*CNT_W-1:0]   link_cnt
);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_QUAL = 2'd1,
        ST_GE   = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [TIMER_W-1:0] QUAL_LAST = TIMER_W'(QUAL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    // Two-flop synchronizer; sync2_q is the only view of ge_ind used below.
    logic [N_CH-1:0]    sync1_q;
    logic [N_CH-1:0]    sync2_q;

    state_e             state_q [N_CH];
    state_e             state_d [N_CH];
    logic [TIMER_W-1:0] timer_q [N_CH];
    logic [TIMER_W-1:0] timer_d [N_CH];
    logic [CNT_W-1:0]   cnt_q   [N_CH];
    logic [CNT_W-1:0]   cnt_d   [N_CH];

    logic [N_CH-1:0]    mode_d;
    logic [N_CH-1:0]    ge_change_q;
    logic [N_CH-1:0]    ge_change_d;
    logic               irq_q;
    logic               irq_d;

    // The timer holds at all-ones instead of wrapping; with a legal
    // QUAL_CYCLES/HOLD_CYCLES the compare values are reached first.
    function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
        return (t == TIMER_MAX) ? t : t + TIMER_W'(1);
    endfunction

    function automatic logic is_ge(input state_e st);
        return (st == ST_GE) || (st == ST_HOLD);
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_125M) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the pre-edge value of every other register.
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            ge_change_q <= '0;
            irq_q       <= 1'b0;
            // NOTE: these per-channel arrays are a handful of flops, not a RAM,
            // so clearing them in reset costs nothing and keeps the state known.
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_LOW;
                timer_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= ge_ind;
            sync2_q     <= sync1_q;
            ge_change_q <= ge_change_d;
            irq_q       <= irq_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: defaults first, so every path assigns and no latch is inferred.
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                ST_LOW: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_QUAL;
                        timer_d[i] = '0;
                    end
                end
                ST_QUAL: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_LOW;
                    end else if (timer_q[i] == QUAL_LAST) begin
                        state_d[i] = ST_GE;
                    end else begin
                        timer_d[i] = timer_inc(timer_q[i]);
                    end
                end
                ST_GE: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_HOLD;
                        timer_d[i] = '0;
                    end
                end
                ST_HOLD: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_GE;
                        timer_d[i] = '0;
                    end else if (timer_q[i] == HOLD_LAST) begin
                        state_d[i] = ST_LOW;
                    end else begin
                        timer_d[i] = timer_inc(timer_q[i]);
                    end
                end
                default: begin
                    state_d[i] = ST_LOW;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    // Status next-values. ge_change follows the ge_mode decode of the next
    // state, so the flag sets on the same edge that ge_mode changes. HOLD->GE
    // keeps ge_mode at 1 and therefore neither flags nor counts.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            mode_d[i] = is_ge(state_d[i]);
            if (mode_d[i] != is_ge(state_q[i])) begin
                ge_change_d[i] = 1'b1;
            end else if (sts_clr[i]) begin
                ge_change_d[i] = 1'b0;
            end else begin
                ge_change_d[i] = ge_change_q[i];
            end

            cnt_d[i] = cnt_q[i];
            if ((state_q[i] == ST_QUAL) && (state_d[i] == ST_GE) && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        irq_d = |(ge_change_q & ~irq_mask);
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ge_mode[i]                  = is_ge(state_q[i]);
            link_cnt[i*CNT_W +: CNT_W]  = cnt_q[i];
        end
        ge_change = ge_change_q;
        irq       = irq_q;
    end

endmodule

// File: tb/tb_gmii_link_mon.sv
// -----------------------------------------------------------------------------
// Testbench for gmii_link_mon with N_CH=2, QUAL_CYCLES=4, HOLD_CYCLES=8, CNT_W=2.
//
// The reference model describes the behaviour as run lengths of the
// synchronised indicator: GE mode is entered after QUAL_CYCLES+1 consecutive
// high observations and left after HOLD_CYCLES+1 consecutive low observations.
// -----------------------------------------------------------------------------
module tb_gmii_link_mon;

    localparam int N_CH    = 2;
    localparam int TIMER_W = 28;
    localparam int QUAL    = 4;
    localparam int HOLD    = 8;
    localparam int CNT_W   = 2;

    logic                  clk_125M = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       ge_ind;
    logic [N_CH-1:0]       irq_mask;
    logic [N_CH-1:0]       sts_clr;
    logic [N_CH-1:0]       ge_mode;
    logic [N_CH-1:0]       ge_change;
    logic                  irq;
    logic [N_CH*CNT_W-1:0] link_cnt;

    int errors = 0;
    int checks = 0;

    gmii_link_mon #(
        .N_CH        (N_CH),
        .TIMER_W     (TIMER_W),
        .HOLD_CYCLES (HOLD),
        .QUAL_CYCLES (QUAL),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_125M  (clk_125M),
        .rst       (rst),
        .ge_ind    (ge_ind),
        .irq_mask  (irq_mask),
        .sts_clr   (sts_clr),
        .ge_mode   (ge_mode),
        .ge_change (ge_change),
        .irq       (irq),
        .link_cnt  (link_cnt)
    );

    always #4 clk_125M = ~clk_125M;

    // ---------------- reference model ----------------
    logic [1:0] m_p1;       // indicator sampled one edge ago
    logic [1:0] m_p2;       // indicator sampled two edges ago (what the FSM sees)
    int         m_hi [2];   // consecutive high observations
    int         m_lo [2];   // consecutive low observations
    logic [1:0] m_mode;
    logic [1:0] m_chg;
    logic       m_irq;
    logic [1:0] m_cnt [2];

    task automatic model_edge();
        logic [1:0] s;
        logic       nm;
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_mode = '0; m_chg = '0; m_irq = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                m_hi[ch] = 0; m_lo[ch] = 0; m_cnt[ch] = '0;
            end
        end else begin
            s     = m_p2;
            m_irq = |(m_chg & ~irq_mask);
            m_p2  = m_p1;
            m_p1  = ge_ind;
            for (int ch = 0; ch < 2; ch++) begin
                if (s[ch]) begin
                    m_hi[ch]++; m_lo[ch] = 0;
                end else begin
                    m_lo[ch]++; m_hi[ch] = 0;
                end
                nm = m_mode[ch];
                if (!m_mode[ch] && m_hi[ch] == QUAL + 1) begin
                    nm = 1'b1;
                    if (m_cnt[ch] != 2'b11) m_cnt[ch] = m_cnt[ch] + 2'd1;
                end
                if (m_mode[ch] && m_lo[ch] == HOLD + 1) nm = 1'b0;
                if (nm != m_mode[ch]) m_chg[ch] = 1'b1;
                else if (sts_clr[ch]) m_chg[ch] = 1'b0;
                m_mode[ch] = nm;
            end
        end
    endtask

    // Advance one edge with the inputs currently driven, then sample #1 later.
    task automatic step();
        @(posedge clk_125M);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".mode"}, 32'(ge_mode),   32'(m_mode));
        check({tag, ".chg"},  32'(ge_change), 32'(m_chg));
        check({tag, ".irq"},  32'(irq),       32'(m_irq));
        check({tag, ".cnt"},  32'(link_cnt),  32'({m_cnt[1], m_cnt[0]}));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [1:0] ind;
        logic [1:0] mask;
        logic [1:0] clr;
        logic [1:0] e_mode;
        logic [1:0] e_chg;
        logic       e_irq;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs [11];
    int   rem  [2];
    logic seen_drop;
    logic seen_chg;

    initial begin
        // Hold ge_ind[0]=1 from reset release: GE on edge 7, irq on edge 8,
        // then a lone clear on edge 9 and irq falling on edge 10.
        vecs[0]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0};
        vecs[1]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0};
        vecs[2]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0};
        vecs[3]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0};
        vecs[4]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0};
        vecs[5]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0};
        vecs[6]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0};
        vecs[7]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 4'h1};
        vecs[8]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 4'h1};
        vecs[9]  = '{1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 4'h1};
        vecs[10] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 4'h1};

        // ---- reset state ----
        rst = 1'b1; ge_ind = 2'b11; irq_mask = 2'b00; sts_clr = 2'b00;
        for (int k = 0; k < 3; k++) step();
        check("reset.mode", 32'(ge_mode),   32'h0);
        check("reset.chg",  32'(ge_change), 32'h0);
        check("reset.irq",  32'(irq),       32'h0);
        check("reset.cnt",  32'(link_cnt),  32'h0);
        rst = 1'b0; ge_ind = 2'b00;
        for (int k = 0; k < 4; k++) begin step(); check_model("idle"); end

        // ---- 3-cycle glitch: qualification aborts ----
        seen_chg = 1'b0;
        ge_ind[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin step(); check_model("glitch"); seen_chg |= ge_mode[0]; end
        ge_ind[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); check_model("glitch"); seen_chg |= ge_mode[0]; end
        check("glitch.mode_never", 32'(seen_chg), 32'h0);
        check("glitch.cnt0", 32'(link_cnt[1:0]), 32'h0);

        // ---- table: rise latency, irq lag, lone clear ----
        for (int v = 0; v < 11; v++) begin
            rst = vecs[v].rst; ge_ind = vecs[v].ind; irq_mask = vecs[v].mask; sts_clr = vecs[v].clr;
            step();
            check($sformatf("vec%0d.mode", v), 32'(ge_mode),   32'(vecs[v].e_mode));
            check($sformatf("vec%0d.chg", v),  32'(ge_change), 32'(vecs[v].e_chg));
            check($sformatf("vec%0d.irq", v),  32'(irq),       32'(vecs[v].e_irq));
            check($sformatf("vec%0d.cnt", v),  32'(link_cnt),  32'(vecs[v].e_cnt));
        end
        sts_clr = 2'b00;

        // ---- short drop while in GE: hold-off recovers silently ----
        seen_drop = 1'b0; seen_chg = 1'b0;
        ge_ind[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(); check_model("recover"); seen_drop |= ~ge_mode[0]; seen_chg |= ge_change[0];
        end
        ge_ind[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(); check_model("recover"); seen_drop |= ~ge_mode[0]; seen_chg |= ge_change[0];
        end
        check("recover.mode_held", 32'(seen_drop), 32'h0);
        check("recover.no_chg",    32'(seen_chg),  32'h0);
        check("recover.cnt",       32'(link_cnt),  32'h1);

        // ---- permanent drop: ge_mode falls on edge 11 ----
        ge_ind[0] = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step(); check_model("fall");
            if (k == 10) check("fall.mode_e10", 32'(ge_mode[0]), 32'h1);
            if (k == 11) begin
                check("fall.mode_e11", 32'(ge_mode[0]),   32'h0);
                check("fall.chg_e11",  32'(ge_change[0]), 32'h1);
            end
        end

        // ---- clear vs set on the same edge, masked irq ----
        irq_mask = 2'b01;
        sts_clr = 2'b01; step(); sts_clr = 2'b00;
        check_model("clr");
        check("clr.lone_pre", 32'(ge_change[0]), 32'h0);
        check("clr.irq_masked", 32'(irq), 32'h0);
        ge_ind[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin step(); check_model("clr"); end
        sts_clr = 2'b01; step(); sts_clr = 2'b00;
        check_model("clr");
        check("clr.rise_mode",   32'(ge_mode[0]),   32'h1);
        check("clr.set_wins",    32'(ge_change[0]), 32'h1);
        for (int k = 0; k < 3; k++) begin
            step(); check_model("clr"); check("clr.irq_masked", 32'(irq), 32'h0);
        end
        sts_clr = 2'b01; step(); sts_clr = 2'b00;
        check_model("clr");
        check("clr.lone_post", 32'(ge_change[0]), 32'h0);

        // ---- channel 1 link-up x5 saturates, then reset mid-HOLD ----
        irq_mask = 2'b00; ge_ind = 2'b00;
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            ge_ind = 2'b10;
            for (int k = 0; k < 8; k++) begin step(); check_model("sat"); end
            ge_ind = 2'b00;
            for (int k = 0; k < 12; k++) begin step(); check_model("sat"); end
            check($sformatf("sat.cnt1_%0d", c), 32'(link_cnt[3:2]), 32'((c > 3) ? 3 : c));
        end
        check("sat.cnt0", 32'(link_cnt[1:0]), 32'h0);
        ge_ind = 2'b10;
        for (int k = 0; k < 8; k++) begin step(); check_model("hold_rst"); end
        ge_ind = 2'b00;
        for (int k = 0; k < 5; k++) begin step(); check_model("hold_rst"); end
        check("hold_rst.in_hold", 32'(ge_mode[1]), 32'h1);
        rst = 1'b1; step(); rst = 1'b0;
        check("hold_rst.mode", 32'(ge_mode),   32'h0);
        check("hold_rst.chg",  32'(ge_change), 32'h0);
        check("hold_rst.irq",  32'(irq),       32'h0);
        check("hold_rst.cnt",  32'(link_cnt),  32'h0);
        for (int k = 0; k < 12; k++) begin step(); check_model("hold_rst"); end

        // ---- randomized run lengths against the model ----
        rem[0] = 0; rem[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rem[ch] == 0) begin
                    ge_ind[ch] = 1'($urandom_range(0, 1));
                    rem[ch] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6))
                                                          : int'($urandom_range(7, 16));
                end
                rem[ch]--;
            end
            if (cyc % 50 == 0) irq_mask = 2'($urandom_range(0, 3));
            sts_clr[0] = ($urandom_range(0, 7) == 0);
            sts_clr[1] = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
